// File: rtl/matrix_result_serializer_if.sv
// Element stream from the matrix result serializer to a narrow consumer.
// A transfer happens on a rising edge where out_valid && out_ready; while out_valid is high
// and out_ready is low, the source holds out_data/out_row/out_col/out_last stable and never drops out_valid.
interface matrix_result_serializer_if #(
    parameter int BitWidth = 8
);
    logic [2*BitWidth-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [1:0]            out_row;
    logic [1:0]            out_col;
    logic                  out_last;

    modport master (
        output out_data, out_valid, out_row, out_col, out_last,
        input  out_ready
    );

    modport slave (
        input  out_data, out_valid, out_row, out_col, out_last,
        output out_ready
    );
endinterface

// File: rtl/matrix_result_serializer.sv
// Snapshots a 3x3 result matrix on capture and streams it row-major, one element per transfer.
// A capture coinciding with the final transfer reloads the snapshot, so matrices stream with no bubble.
module matrix_result_serializer #(
    parameter int BitWidth = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  capture,
    input  logic [2*BitWidth-1:0] C00,
    input  logic [2*BitWidth-1:0] C01,
    input  logic [2*BitWidth-1:0] C02,
    input  logic [2*BitWidth-1:0] C10,
    input  logic [2*BitWidth-1:0] C11,
    input  logic [2*BitWidth-1:0] C12,
    input  logic [2*BitWidth-1:0] C20,
    input  logic [2*BitWidth-1:0] C21,
    input  logic [2*BitWidth-1:0] C22,
    matrix_result_serializer_if.master o_stream,
    output logic                  busy,
    output logic                  overrun,
    output logic                  o_dbg_state
);
    localparam int DW = 2 * BitWidth;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [DW-1:0] r_snap [9];
    logic [DW-1:0] w_snap_next [9];
    logic [DW-1:0] w_in [9];
    logic [3:0]    r_index;
    logic [3:0]    w_index_next;
    logic [DW-1:0] r_data;
    logic [DW-1:0] w_data_next;
    logic [1:0]    r_row;
    logic [1:0]    w_row_next;
    logic [1:0]    r_col;
    logic [1:0]    w_col_next;
    logic          r_last;
    logic          w_last_next;
    logic          r_overrun;
    logic          w_xfer;
    logic          w_final;
    logic          w_load;
    logic          w_overrun_hit;

    always_comb begin
        w_in[0] = C00; w_in[1] = C01; w_in[2] = C02;
        w_in[3] = C10; w_in[4] = C11; w_in[5] = C12;
        w_in[6] = C20; w_in[7] = C21; w_in[8] = C22;
    end

    always_comb begin
        w_state_next  = r_state;
        w_index_next  = r_index;
        w_snap_next   = r_snap;
        w_data_next   = '0;
        w_row_next    = 2'd0;
        w_col_next    = 2'd0;
        w_last_next   = 1'b0;

        w_xfer        = (r_state == S_STREAM) && o_stream.out_ready;
        w_final       = w_xfer && (r_index == 4'd8);
        w_load        = capture && ((r_state == S_IDLE) || w_final);
        w_overrun_hit = capture && (r_state == S_STREAM) && !w_final;

        case (r_state)
            S_IDLE: begin
                if (w_load) begin
                    w_snap_next  = w_in;
                    w_index_next = 4'd0;
                    w_state_next = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_load) begin
                    w_snap_next  = w_in;
                    w_index_next = 4'd0;
                end else if (w_final) begin
                    w_index_next = 4'd0;
                    w_state_next = S_IDLE;
                end else if (w_xfer) begin
                    w_index_next = r_index + 4'd1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        // Outputs are precomputed from the next index so every port comes straight from a flop.
        if (w_state_next == S_STREAM) begin
            w_data_next = w_snap_next[w_index_next];
            w_last_next = (w_index_next == 4'd8);
            case (w_index_next)
                4'd0: begin w_row_next = 2'd0; w_col_next = 2'd0; end
                4'd1: begin w_row_next = 2'd0; w_col_next = 2'd1; end
                4'd2: begin w_row_next = 2'd0; w_col_next = 2'd2; end
                4'd3: begin w_row_next = 2'd1; w_col_next = 2'd0; end
                4'd4: begin w_row_next = 2'd1; w_col_next = 2'd1; end
                4'd5: begin w_row_next = 2'd1; w_col_next = 2'd2; end
                4'd6: begin w_row_next = 2'd2; w_col_next = 2'd0; end
                4'd7: begin w_row_next = 2'd2; w_col_next = 2'd1; end
                4'd8: begin w_row_next = 2'd2; w_col_next = 2'd2; end
                default: begin w_row_next = 2'd0; w_col_next = 2'd0; end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_index   <= 4'd0;
            for (int i = 0; i < 9; i++) begin
                r_snap[i] <= '0;
            end
            r_data    <= '0;
            r_row     <= 2'd0;
            r_col     <= 2'd0;
            r_last    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_index   <= w_index_next;
            r_snap    <= w_snap_next;
            r_data    <= w_data_next;
            r_row     <= w_row_next;
            r_col     <= w_col_next;
            r_last    <= w_last_next;
            if (w_overrun_hit) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_stream.out_valid = (r_state == S_STREAM);
    assign o_stream.out_data  = r_data;
    assign o_stream.out_row   = r_row;
    assign o_stream.out_col   = r_col;
    assign o_stream.out_last  = r_last;
    assign busy               = (r_state == S_STREAM);
    assign overrun            = r_overrun;
    assign o_dbg_state        = r_state;
endmodule

// File: tb/tb_matrix_result_serializer.sv
// Directed bench for matrix_result_serializer: drain, backpressure, back-to-back, overrun,
// reset mid-stream and full-width data, with a transfer scoreboard fed from the stimulus matrices.
module tb_matrix_result_serializer;
    logic        clk;
    logic        reset;
    logic        capture;
    logic [15:0] c_drv [9];
    logic        busy;
    logic        overrun;
    logic        dbg_state;

    logic [15:0] mat_a [9] = '{16'd30, 16'd24, 16'd18, 16'd84, 16'd69, 16'd54, 16'd138, 16'd114, 16'd90};
    logic [3:0]  bp_pat [4] = '{4'd1, 4'd0, 4'd0, 4'd1};

    logic [20:0] exp_q [$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic        hold_pending = 1'b0;
    logic [20:0] hold_val = '0;
    int          drain_cyc;

    matrix_result_serializer_if #(.BitWidth(8)) bus ();

    matrix_result_serializer #(.BitWidth(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .capture    (capture),
        .C00        (c_drv[0]),
        .C01        (c_drv[1]),
        .C02        (c_drv[2]),
        .C10        (c_drv[3]),
        .C11        (c_drv[4]),
        .C12        (c_drv[5]),
        .C20        (c_drv[6]),
        .C21        (c_drv[7]),
        .C22        (c_drv[8]),
        .o_stream   (bus.master),
        .busy       (busy),
        .overrun    (overrun),
        .o_dbg_state(dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp();
        for (int k = 0; k < 9; k++) begin
            exp_q.push_back({c_drv[k], 2'(k / 3), 2'(k % 3), (k == 8)});
        end
    endtask

    // Drives one capture of the given matrix; returns just after the capturing edge.
    task automatic start_capture(input logic [15:0] m [9]);
        c_drv   = m;
        capture = 1'b1;
        push_exp();
        tick();
        capture = 1'b0;
    endtask

    task automatic check_stream(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("stream_valid", 32'(bus.out_valid), 32'd1);
            tick();
        end
    endtask

    // Scoreboard: every accepted element is popped and compared; held elements must not change.
    always @(negedge clk) begin
        if (reset) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_fields", 32'({bus.out_data, bus.out_row, bus.out_col, bus.out_last}), 32'(hold_val));
            end
            if (bus.out_valid && bus.out_ready) begin
                check("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("xfer_elem", 32'({bus.out_data, bus.out_row, bus.out_col, bus.out_last}),
                          32'(exp_q.pop_front()));
                end
            end
            hold_pending = bus.out_valid && !bus.out_ready;
            hold_val     = {bus.out_data, bus.out_row, bus.out_col, bus.out_last};
        end
    end

    initial begin
        logic [15:0] mat_k [9];
        reset         = 1'b1;
        capture       = 1'b0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 9; k++) c_drv[k] = 16'd0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        check("rst_row", 32'(bus.out_row), 32'd0);
        check("rst_col", 32'(bus.out_col), 32'd0);
        check("rst_last", 32'(bus.out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        tick();

        // Basic drain with ready high
        bus.out_ready = 1'b1;
        start_capture(mat_a);
        @(negedge clk);
        check("lat_valid", 32'(bus.out_valid), 32'd1);
        check("lat_data", 32'(bus.out_data), 32'd30);
        check("lat_busy", 32'(busy), 32'd1);
        tick();
        check_stream(7);
        @(negedge clk);
        check("drain_last_data", 32'(bus.out_data), 32'd90);
        check("drain_last", 32'(bus.out_last), 32'd1);
        tick();
        @(negedge clk);
        check("drain_end_valid", 32'(bus.out_valid), 32'd0);
        check("drain_end_last", 32'(bus.out_last), 32'd0);
        check("drain_end_busy", 32'(busy), 32'd0);
        check("drain_q_empty", 32'(exp_q.size()), 32'd0);
        tick();

        // Backpressure with ready pattern 1,0,0,1
        start_capture(mat_a);
        drain_cyc = 0;
        while (exp_q.size() != 0 && drain_cyc < 100) begin
            bus.out_ready = bp_pat[drain_cyc % 4][0];
            tick();
            drain_cyc++;
        end
        check("bp_done", 32'(exp_q.size()), 32'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_end_valid", 32'(bus.out_valid), 32'd0);
        tick();

        // Back-to-back: second capture on the edge transferring element (2,2)
        start_capture(mat_a);
        check_stream(8);
        for (int k = 0; k < 9; k++) mat_k[k] = 16'd7;
        @(negedge clk);
        check("b2b_pre_last", 32'(bus.out_last), 32'd1);
        start_capture(mat_k);
        @(negedge clk);
        check("b2b_valid", 32'(bus.out_valid), 32'd1);
        check("b2b_data", 32'(bus.out_data), 32'd7);
        check("b2b_row", 32'(bus.out_row), 32'd0);
        check("b2b_col", 32'(bus.out_col), 32'd0);
        check("b2b_overrun", 32'(overrun), 32'd0);
        tick();
        check_stream(8);
        @(negedge clk);
        check("b2b_end_valid", 32'(bus.out_valid), 32'd0);
        check("b2b_q_empty", 32'(exp_q.size()), 32'd0);
        tick();

        // Overrun: capture while element (1,1) is pending under backpressure
        start_capture(mat_a);
        check_stream(4);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 9; k++) c_drv[k] = 16'd5;
        capture = 1'b1;
        tick();
        capture = 1'b0;
        @(negedge clk);
        check("or_set", 32'(overrun), 32'd1);
        check("or_data", 32'(bus.out_data), 32'd69);
        check("or_row", 32'(bus.out_row), 32'd1);
        check("or_col", 32'(bus.out_col), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        drain_cyc = 0;
        while (exp_q.size() != 0 && drain_cyc < 50) begin
            tick();
            drain_cyc++;
        end
        check("or_drain_done", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("or_end_valid", 32'(bus.out_valid), 32'd0);
        check("or_sticky", 32'(overrun), 32'd1);
        tick();

        // Reset mid-stream during element (1,0), together with a capture
        start_capture(mat_a);
        check_stream(3);
        @(negedge clk);
        check("mid_elem_row", 32'(bus.out_row), 32'd1);
        reset   = 1'b1;
        capture = 1'b1;
        for (int k = 0; k < 9; k++) c_drv[k] = 16'd5;
        tick();
        reset   = 1'b0;
        capture = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_data", 32'(bus.out_data), 32'd0);
        check("mid_rst_row", 32'(bus.out_row), 32'd0);
        check("mid_rst_col", 32'(bus.out_col), 32'd0);
        check("mid_rst_last", 32'(bus.out_last), 32'd0);
        check("mid_rst_overrun", 32'(overrun), 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'd0);
        tick();

        // Restart after reset with a full-width C22
        mat_k = mat_a;
        mat_k[8] = 16'hFFFF;
        start_capture(mat_k);
        @(negedge clk);
        check("restart_data", 32'(bus.out_data), 32'd30);
        check("restart_row", 32'(bus.out_row), 32'd0);
        check("restart_col", 32'(bus.out_col), 32'd0);
        tick();
        check_stream(7);
        @(negedge clk);
        check("width_data", 32'(bus.out_data), 32'hFFFF);
        check("width_last", 32'(bus.out_last), 32'd1);
        tick();
        @(negedge clk);
        check("width_end_valid", 32'(bus.out_valid), 32'd0);
        check("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/matrix_result_serializer.md
# matrix_result_serializer

- Downstream stage of the 3x3 matrix multiplier.
- Snapshots the nine flattened result words C00..C22 on a `capture` strobe.
- Streams the snapshot out one element per transfer, row-major, over a valid/ready handshake, with row/column tags and an end-of-matrix marker.
- Lets the multiplier start its next product while the previous one drains to a narrow consumer.

## Interface
- BitWidth, 8, input operand width of the multiplier; result words are 2*BitWidth wide.
- clk  input  1  rising-edge clock, single clock domain.
- reset  input  1  synchronous, active-high reset.
- capture  input  1  one-cycle strobe: C00..C22 are valid this cycle and must be snapshotted.
- C00..C22  input  2*BitWidth each  result matrix from the multiplier (nine separate ports, same names as the multiplier outputs).
- out_data  output  2*BitWidth  current element.
- out_valid  output  1  out_data/out_row/out_col/out_last are valid.
- out_ready  input  1  consumer accepts the element this cycle.
- out_row  output  2  row index of the current element (0..2).
- out_col  output  2  column index of the current element (0..2).
- out_last  output  1  high with element (2,2).
- busy  output  1  snapshot held and not fully drained (equals out_valid).
- overrun  output  1  sticky: a capture was dropped; cleared only by reset.

## Operation
- Two-state FSM: IDLE and STREAM. Holds a 9-entry snapshot register and a 4-bit element index 0..8. Index k maps to row k/3, col k%3.
- IDLE:
  - out_valid=0.
  - capture=1 loads all nine inputs into the snapshot, sets index=0, and moves to STREAM.
- STREAM:
  - out_valid=1; out_data=snapshot[index]; out_row/out_col decoded from index; out_last=(index==8).
- Transfer occurs on a clock edge where out_valid && out_ready.
  - index<8: index increments.
  - index==8: FSM returns to IDLE, unless capture is also high that cycle (see below).
- out_valid && !out_ready: out_data, out_row, out_col and out_last must hold stable. out_valid never drops without a transfer.
- capture in STREAM, no final transfer that cycle: capture is ignored, overrun is set to 1, and the snapshot is unchanged.
- capture on the same edge as the transfer of element 8: accepted.
  - New snapshot is loaded, index=0, FSM stays in STREAM (back-to-back matrices, no bubble).
  - overrun is not set.
- capture on the edge that transfers element 0..7: ignored and overrun set, as above.
- Data is passed through unmodified: no truncation, no sign handling, full 2*BitWidth.
- Reset values:
  - out_valid=0, out_last=0, busy=0, overrun=0.
  - out_data=0, out_row=0, out_col=0.
  - snapshot all zero, index=0, FSM=IDLE.
- Reset mid-stream aborts the stream immediately. Reset has priority over capture and transfer in the same cycle.

## Timing
- Capture on edge t: out_valid=1 with element (0,0) from just after t. Latency is one cycle.
- out_ready held high: one element per cycle. Nine cycles drain a matrix, out_last on the 9th.
- Back-to-back captures spaced exactly 9 cycles, with ready high throughout: continuous stream with no idle cycle between matrices.
- After the final transfer with no concurrent capture, out_valid=0 in the following cycle.
- All outputs are registered; there is no combinational path from out_ready or capture to any output.

## Test plan
- Basic drain:
  - Stimulus: reset, then capture with C = {30,24,18; 84,69,54; 138,114,90}, ready held high.
  - Required response: out_data 30,24,18,84,69,54,138,114,90 on 9 consecutive cycles; row/col (0,0)..(2,2); out_last only on 90; out_valid low the next cycle.
- Backpressure:
  - Stimulus: same data, out_ready toggled 1,0,0,1,…
  - Required response: each element held stable while ready=0; exactly 9 transfers in order; no duplicates or drops.
- Back-to-back:
  - Stimulus: second capture (C all = 7) asserted on the edge that transfers 90.
  - Required response: 7 appears as (0,0) the very next cycle; overrun stays 0.
- Overrun:
  - Stimulus: capture with C all = 5 while element (1,1) is pending.
  - Required response: overrun goes to 1 and stays 1; the remaining stream is still 69,54,138,114,90.
- Reset mid-stream:
  - Stimulus: reset asserted during element (1,0) for one cycle, together with capture.
  - Required response: all outputs 0 the next cycle, FSM in IDLE, overrun 0. A subsequent capture restarts cleanly at (0,0).
- Width:
  - Stimulus: BitWidth=8, C22=16'hFFFF.
  - Required response: out_data=16'hFFFF on the last element, no truncation.
